// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: opcode values and FSM state type.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_AND = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the ALU execution unit; master issues, slave executes.
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                start;
  logic [ALU_OP_W-1:0] ALUCtr;
  logic [WIDTH-1:0]    srcA;
  logic [WIDTH-1:0]    srcB;
  logic [WIDTH-1:0]    result;
  logic                zero;
  logic                err;
  logic                done;
  logic                busy;

  modport master (
    output start, ALUCtr, srcA, srcB,
    input  result, zero, err, done, busy
  );

  modport slave (
    input  start, ALUCtr, srcA, srcB,
    output result, zero, err, done, busy
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier datapath: one partial-product step per cycle, WIDTH steps.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             last,
  output logic [WIDTH-1:0] acc_next
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // The final step's sum is exposed combinationally so the top can capture it
  // on the same edge that leaves the MUL state.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  // The datapath registers are few and are cleared on reset so an aborted
  // multiply leaves no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= CNT_W'(WIDTH);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/or/and, multi-cycle unsigned multiply,
// registered result/zero/err with a one-cycle done pulse.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);

  alu_state_e       state;
  alu_state_e       state_next;
  logic             accept;
  logic             op_is_mul;
  logic             mul_load;
  logic             mul_last;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  assign accept    = bus.start && (state != S_MUL);
  assign op_is_mul = (bus.ALUCtr == ALU_MUL);
  assign mul_load  = accept && op_is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load),
    .step      (state == S_MUL),
    .mcand_in  (bus.srcA),
    .mplier_in (bus.srcB),
    .last      (mul_last),
    .acc_next  (mul_acc_next)
  );

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.ALUCtr)
      ALU_ADD: alu_res = bus.srcA + bus.srcB;
      ALU_SUB: alu_res = bus.srcA - bus.srcB;
      ALU_OR:  alu_res = bus.srcA | bus.srcB;
      ALU_AND: alu_res = bus.srcA & bus.srcB;
      ALU_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)               state_next = op_is_mul ? S_MUL : S_DONE;
        else if (state == S_DONE) state_next = S_IDLE;
      end
      S_MUL:   if (mul_last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Outputs change only on the edge that enters DONE and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else if (state == S_MUL && mul_last) begin
      result_q <= mul_acc_next;
      zero_q   <= (mul_acc_next == '0);
      err_q    <= 1'b0;
    end else if (accept && !op_is_mul) begin
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      err_q    <= alu_err;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
  assign bus.done   = (state == S_DONE);
  assign bus.busy   = (state == S_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  localparam int WIDTH  = 32;
  localparam int BUDGET = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge, then scramble operands to show they are not reused.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.ALUCtr = op;
    bus.srcA   = a;
    bus.srcB   = b;
    tick();
    bus.start  = 1'b0;
    bus.srcA   = 32'hDEAD_BEEF;
    bus.srcB   = 32'h1234_5678;
    bus.ALUCtr = 3'b000;
  endtask

  // Latency counts the cycle right after the accept edge as 1.
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!bus.done && lat < BUDGET) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    if (!bus.done) check({tag, "_timeout"}, 32'(lat), 32'(BUDGET + 1));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_err, input int exp_lat);
    int lat, bc;
    issue(op, a, b);
    wait_done(tag, lat, bc);
    check({tag, "_lat"},    32'(lat),   32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_zero"},   32'(bus.zero), 32'(exp_zero));
    check({tag, "_err"},    32'(bus.err),  32'(exp_err));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  initial begin
    int lat, bc, nd;
    bus.start  = 1'b0;
    bus.ALUCtr = 3'b000;
    bus.srcA   = '0;
    bus.srcB   = '0;

    repeat (2) tick();
    check("rst_result", bus.result, 32'h0);
    check("rst_zero",   32'(bus.zero), 32'd1);
    check("rst_err",    32'(bus.err),  32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("hold_result", bus.result, 32'h0);

    run_op("sub",   3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run_op("or",    3'b010, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1);
    run_op("and",   3'b011, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 1'b1, 1'b0, 1);
    run_op("ill110", 3'b110, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 1);
    run_op("ill101", 3'b101, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 1);
    run_op("ill111", 3'b111, 32'h7, 32'h9, 32'h0, 1'b1, 1'b1, 1);
    run_op("add_after_err", 3'b000, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1);

    issue(3'b100, 32'h0001_0003, 32'h0000_0005);
    wait_done("mul", lat, bc);
    check("mul_lat",    32'(lat), 32'd33);
    check("mul_busy",   32'(bc),  32'd32);
    check("mul_result", bus.result, 32'h0005_000F);
    check("mul_err",    32'(bus.err), 32'd0);

    run_op("mul_max", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 33);
    run_op("mul_zero", 3'b100, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b0, 33);
    run_op("mul_hi", 3'b100, 32'h8000_0001, 32'h3, 32'h8000_0003, 1'b0, 1'b0, 33);

    // A start during MUL must be dropped; an add issued in the DONE cycle must follow at once.
    issue(3'b100, 32'd7, 32'd6);
    repeat (3) tick();
    bus.start  = 1'b1;
    bus.ALUCtr = 3'b000;
    bus.srcA   = 32'd1;
    bus.srcB   = 32'd1;
    tick();
    bus.start  = 1'b0;
    wait_done("mul_ign", lat, bc);
    check("mul_ign_lat",    32'(lat), 32'd29);
    check("mul_ign_result", bus.result, 32'd42);
    issue(3'b000, 32'd2, 32'd3);
    check("b2b_done",   32'(bus.done), 32'd1);
    check("b2b_result", bus.result, 32'd5);
    count_dones(40, nd);
    check("no_extra_done", 32'(nd), 32'd0);
    check("hold_b2b", bus.result, 32'd5);

    // Abort a multiply with reset ten cycles in.
    issue(3'b100, 32'h0001_0003, 32'h0000_0005);
    repeat (9) tick();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy), 32'd0);
    check("arst_done",   32'(bus.done), 32'd0);
    check("arst_result", bus.result, 32'h0);
    check("arst_zero",   32'(bus.zero), 32'd1);
    check("arst_err",    32'(bus.err),  32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, nd);
    check("post_rst_no_done", 32'(nd), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    run_op("post_rst_add", 3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled on the rising edge only when the unit is ready to accept.
REQ-005 ALUCtr  input  3  operation code: 000 add, 001 sub, 010 or, 011 and, 100 mul, 101-111 illegal.
REQ-006 srcA  input  WIDTH  first operand.
REQ-007 srcB  input  WIDTH  second operand.
REQ-008 result  output  WIDTH  registered result of the last completed operation.
REQ-009 zero  output  1  registered flag, high when result equals 0.
REQ-010 err  output  1  registered flag, high when the last completed operation had an illegal ALUCtr.
REQ-011 done  output  1  one-cycle completion pulse; result, zero and err are valid while it is high.
REQ-012 busy  output  1  high while a multiply is iterating; start is ignored while high.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MUL and DONE.
REQ-014 In IDLE or DONE, start=1 is accepted; ALUCtr, srcA and srcB are captured on that edge.
REQ-015 An accepted add, sub, or, and, or illegal op SHALL move to DONE on the accept edge, so done is high in the cycle after the accept edge (latency 1).
REQ-016 add/sub SHALL wrap modulo 2^WIDTH; there is no carry or overflow output.
REQ-017 An illegal op SHALL give result=0, zero=1 and err=1; every legal op SHALL give err=0.
REQ-018 An accepted mul SHALL go to MUL, clear the accumulator and load the iteration counter with WIDTH.
REQ-019 Each MUL cycle SHALL do one shift-add step and decrement the counter; when the counter reaches 0 the FSM moves to DONE, so done is high WIDTH+1 cycles after the accept edge.
REQ-020 The mul result SHALL be the low WIDTH bits of the unsigned product srcA*srcB.
REQ-021 start while in MUL SHALL be ignored; nothing is queued and no later done is produced for it.
REQ-022 DONE SHALL last exactly one cycle; it returns to IDLE, or accepts a new start on that edge, giving back-to-back throughput.
REQ-023 result, zero and err SHALL hold their values until the next done cycle; they are updated only on the edge that enters DONE.
REQ-024 busy SHALL equal (state==MUL) and done SHALL equal (state==DONE); neither depends combinationally on any input.
REQ-025 Operand changes after the accept edge SHALL NOT affect the operation in flight.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, result=0, zero=1, err=0, done=0, busy=0, and clear the counter and accumulator.
REQ-027 Reset during MUL or DONE SHALL abort the operation; no done pulse follows reset release until a new start is accepted.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package alu_pkg SHALL hold the ALUCtr encodings (ALU_ADD..ALU_MUL) and the FSM state type.
REQ-030 The shift-add datapath (accumulator, shifted multiplicand, multiplier, counter) SHALL be one sub-module, alu_mul_seq, with load/step inputs and a last-step output.
REQ-031 The expected implementation size is 120-400 lines of RTL in total.

Verification
REQ-032 add: srcA=0xFFFFFFFF, srcB=1, start one cycle -> next cycle done=1, result=0, zero=1, err=0.
REQ-033 sub and or/and: sub 5-7 -> result=0xFFFFFFFE, zero=0; or 0xF0F0_0000|0x0000_0F0F -> 0xF0F00F0F; and of the same operands -> 0.
REQ-034 mul: 0x0001_0003*0x0000_0005 -> done exactly 33 cycles after accept, result=0x0005_000F, busy high for 32 cycles.
REQ-035 start pulsed during MUL with ALUCtr=000 -> ignored, exactly one done, mul result intact; add issued in the DONE cycle -> done again one cycle later.
REQ-036 ALUCtr=110 -> done next cycle, err=1, result=0, zero=1.
REQ-037 rst_n pulled low 10 cycles into a mul -> outputs at reset values immediately, no done after release, then a fresh add completes correctly.
